// File: rtl/switch_debouncer_pkg.sv
// Shared constants, channel state encoding and elaboration-time sizing helpers.
// Pure declarations: no logic, no latency, no flow control.
package switch_debouncer_pkg;

    localparam int SW_MODE0 = 0;
    localparam int SW_MODE1 = 1;
    localparam int SW_PAUSE = 2;

    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_CONFIRM = 1'b1
    } db_state_t;

    function automatic int calc_div(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

    function automatic int calc_cnt_w(input int stable_samples);
        return $clog2(stable_samples + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: 2-FF synchroniser, tick-driven confirm FSM, registered level and edge pulses.
// Latency 2 cycles + STABLE_SAMPLES ticks (+1 cycle to register); no backpressure.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int   STABLE_SAMPLES = 20,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int               CNT_W    = calc_cnt_w(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    db_state_t        r_state;
    logic             w_differs;

    assign w_differs = (r_sync != r_stable);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta   <= RESET_LEVEL;
            r_sync   <= RESET_LEVEL;
            r_stable <= RESET_LEVEL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= DB_IDLE;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_tick) begin
                case (r_state)
                    DB_IDLE: begin
                        if (!w_differs) begin
                            r_cnt <= '0;
                        end else if (STABLE_SAMPLES == 1) begin
                            // A single differing sample is enough: accept without confirming.
                            r_stable <= r_sync;
                            r_rise   <= r_sync;
                            r_fall   <= ~r_sync;
                            r_cnt    <= '0;
                        end else begin
                            r_state <= DB_CONFIRM;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    DB_CONFIRM: begin
                        if (!w_differs) begin
                            r_state <= DB_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_stable <= r_sync;
                            r_rise   <= r_sync;
                            r_fall   <= ~r_sync;
                            r_state  <= DB_IDLE;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= DB_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces NUM_SW slide switches off one shared sample-tick prescaler.
// Latency 2 cycles + STABLE_SAMPLES ticks (up to 1 tick of phase jitter); no backpressure.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int   NUM_SW         = 3,
    parameter int   CLK_HZ         = 50_000_000,
    parameter int   SAMPLE_HZ      = 1_000,
    parameter int   STABLE_SAMPLES = 20,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic              clki,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sample_tick
);

    localparam int               DIV      = calc_div(CLK_HZ, SAMPLE_HZ);
    localparam int               PRE_W    = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("switch_debouncer: CLK_HZ/SAMPLE_HZ must be at least 2");
    end
    if (STABLE_SAMPLES < 1) begin : g_bad_samples
        $error("switch_debouncer: STABLE_SAMPLES must be at least 1");
    end

    logic [PRE_W-1:0] r_presc;
    logic             r_tick;

    // The tick is registered, so it lands one cycle after the counter reaches DIV-1.
    always_ff @(posedge clki) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= (r_presc == PRE_LAST);
            r_presc <= (r_presc == PRE_LAST) ? '0 : r_presc + PRE_W'(1);
        end
    end

    assign sample_tick = r_tick;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_ch (
            .i_clk    (clki),
            .i_reset  (reset),
            .i_tick   (r_tick),
            .i_raw    (sw_raw[g]),
            .o_stable (sw_stable[g]),
            .o_rise   (sw_rise[g]),
            .o_fall   (sw_fall[g])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: stimulus feeds a sample-history reference model that queues expected
// pulse events; a negedge monitor pops and compares them against the DUT outputs.
module tb_switch_debouncer;

    localparam int NSW       = 3;
    localparam int CLK_HZ    = 1000;
    localparam int SAMPLE_HZ = 100;
    localparam int N         = 4;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;

    logic           clki   = 1'b0;
    logic           reset  = 1'b1;
    logic [NSW-1:0] sw_raw = '0;
    logic [NSW-1:0] sw_stable;
    logic [NSW-1:0] sw_rise;
    logic [NSW-1:0] sw_fall;
    logic           sample_tick;

    switch_debouncer #(
        .NUM_SW         (NSW),
        .CLK_HZ         (CLK_HZ),
        .SAMPLE_HZ      (SAMPLE_HZ),
        .STABLE_SAMPLES (N),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clki        (clki),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .sw_stable   (sw_stable),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall),
        .sample_tick (sample_tick)
    );

    always #5 clki = ~clki;

    typedef struct {
        int             cyc;
        logic [NSW-1:0] rise;
        logic [NSW-1:0] fall;
        logic [NSW-1:0] stable;
    } ev_t;

    ev_t            exp_q[$];
    logic [NSW-1:0] samp_q[$];
    ev_t            mon_ev;
    int             checks = 0;
    int             errors = 0;
    int             edge_n = 0;
    bit             in_reset = 1'b1;
    bit             started = 1'b0;
    logic [NSW-1:0] m_stable = '0;
    logic [NSW-1:0] exp_vis = '0;
    logic [NSW-1:0] prev_raw = '0;
    int             rise_cnt[NSW];
    int             fall_cnt[NSW];
    int             snap_r[NSW];
    int             snap_f[NSW];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock: drive at negedge, then advance the reference model past the posedge.
    // A change is accepted once the last N tick samples all differ from the stable level.
    task automatic cyc(input logic [NSW-1:0] raw, input logic rst);
        logic [NSW-1:0] acc;
        ev_t            ev;
        @(negedge clki);
        sw_raw = raw;
        reset  = rst;
        @(posedge clki);
        started = 1'b1;
        if (rst) begin
            in_reset = 1'b1;
            edge_n   = 0;
            samp_q.delete();
            exp_q.delete();
            m_stable = '0;
        end else begin
            in_reset = 1'b0;
            edge_n++;
            if (edge_n % DIV == 0) begin
                samp_q.push_back(prev_raw);
                if (samp_q.size() > N) void'(samp_q.pop_front());
                acc = '0;
                if (samp_q.size() == N) begin
                    for (int b = 0; b < NSW; b++) begin
                        acc[b] = 1'b1;
                        foreach (samp_q[i]) if (samp_q[i][b] == m_stable[b]) acc[b] = 1'b0;
                    end
                end
                if (acc != '0) begin
                    ev.cyc    = edge_n + 1;
                    ev.rise   = acc & ~m_stable;
                    ev.fall   = acc & m_stable;
                    m_stable  = m_stable ^ acc;
                    ev.stable = m_stable;
                    exp_q.push_back(ev);
                end
            end
        end
        prev_raw = raw;
    endtask

    task automatic run(input logic [NSW-1:0] raw, input int n);
        for (int i = 0; i < n; i++) cyc(raw, 1'b0);
    endtask

    task automatic snap();
        for (int b = 0; b < NSW; b++) begin
            snap_r[b] = rise_cnt[b];
            snap_f[b] = fall_cnt[b];
        end
    endtask

    // Directed check of level and pulse counts since the last snapshot, sampled off the edge.
    task automatic dcheck(input string name, input logic [NSW-1:0] stable,
                          input logic [NSW-1:0] rises, input logic [NSW-1:0] falls);
        logic [NSW-1:0] r_act;
        logic [NSW-1:0] f_act;
        #1;
        for (int b = 0; b < NSW; b++) begin
            r_act[b] = (rise_cnt[b] - snap_r[b]) != 0;
            f_act[b] = (fall_cnt[b] - snap_f[b]) != 0;
            if (rise_cnt[b] - snap_r[b] > 1 || fall_cnt[b] - snap_f[b] > 1) begin
                r_act[b] = 1'bx;
            end
        end
        check({name, "_stable"}, {13'b0, sw_stable}, {13'b0, stable});
        check({name, "_rises"}, {13'b0, r_act}, {13'b0, rises});
        check({name, "_falls"}, {13'b0, f_act}, {13'b0, falls});
    endtask

    always @(negedge clki) begin
        if (started) begin
            if (in_reset) begin
                exp_vis = '0;
                check("reset_outputs", {6'b0, sample_tick, sw_stable, sw_rise, sw_fall}, 16'h0);
            end else begin
                check("sample_tick", {15'b0, sample_tick}, {15'b0, (edge_n % DIV == 0)});
                if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                    mon_ev = exp_q.pop_front();
                    check("rise_pulse", {13'b0, sw_rise}, {13'b0, mon_ev.rise});
                    check("fall_pulse", {13'b0, sw_fall}, {13'b0, mon_ev.fall});
                    exp_vis = mon_ev.stable;
                end else begin
                    check("no_pulse", {10'b0, sw_rise, sw_fall}, 16'h0);
                end
                check("stable_level", {13'b0, sw_stable}, {13'b0, exp_vis});
                check("rise_fall_exclusive", {13'b0, sw_rise & sw_fall}, 16'h0);
                for (int b = 0; b < NSW; b++) begin
                    rise_cnt[b] += int'(sw_rise[b]);
                    fall_cnt[b] += int'(sw_fall[b]);
                end
            end
        end
    end

    initial begin
        for (int b = 0; b < NSW; b++) begin
            rise_cnt[b] = 0;
            fall_cnt[b] = 0;
        end
        snap();

        // Reset held with all switches on, then release: one joint rise after 4 ticks.
        for (int i = 0; i < 3; i++) cyc(3'b111, 1'b1);
        run(3'b111, 60);
        dcheck("reset_release", 3'b111, 3'b111, 3'b000);

        snap();
        run(3'b000, 60);
        dcheck("simultaneous_release", 3'b000, 3'b000, 3'b111);

        snap();
        run(3'b001, 60);
        dcheck("clean_edge", 3'b001, 3'b001, 3'b000);

        // Bit 2 bounces 1,0,1 across consecutive ticks before settling high.
        snap();
        run(3'b101, DIV);
        run(3'b001, DIV);
        run(3'b101, 60);
        dcheck("bounce", 3'b101, 3'b100, 3'b000);

        // Bit 1 pulses high for 5 cycles strictly between sample points.
        snap();
        while (edge_n % DIV != 1) cyc(3'b101, 1'b0);
        run(3'b111, 5);
        run(3'b101, 50);
        dcheck("short_glitch", 3'b101, 3'b000, 3'b000);

        for (int i = 0; i < 300; i++) begin
            run(3'($urandom_range(0, 7)), $urandom_range(1, 45));
        end

        run(3'b000, 60);
        snap();
        dcheck("pre_midconfirm", 3'b000, 3'b000, 3'b000);

        // Reset after two of four confirming samples: count must restart afterwards.
        while (edge_n % DIV != 0) cyc(3'b000, 1'b0);
        run(3'b101, 2 * DIV + 1);
        cyc(3'b101, 1'b1);
        dcheck("midconfirm_in_reset", 3'b000, 3'b000, 3'b000);
        cyc(3'b101, 1'b1);
        run(3'b101, 3 * DIV + 5);
        dcheck("midconfirm_restart", 3'b000, 3'b000, 3'b000);
        run(3'b101, 20);
        dcheck("midconfirm_accept", 3'b101, 3'b101, 3'b000);

        // Switches at the reset level through reset must not produce any pulse.
        snap();
        for (int i = 0; i < 3; i++) cyc(3'b000, 1'b1);
        run(3'b000, 60);
        dcheck("quiet_reset", 3'b000, 3'b000, 3'b000);

        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions raw slide-switch inputs (MODE bit 0, MODE bit 1, PAUSE) before they reach the LED pattern controller.
- Per-channel 2-FF synchroniser, then counter-based debounce on a slow sample tick.
- Outputs are clean levels plus one-cycle rise and fall pulses.
- Sits between board pins and LEDController, clocked from the 50 MHz board clock.

Parameters:
- NUM_SW, 3, number of switch channels (bit0 = sw_mode0, bit1 = sw_mode1, bit2 = sw_pause).
- CLK_HZ, 50_000_000, input clock frequency.
- SAMPLE_HZ, 1_000, debounce sample rate.
- STABLE_SAMPLES, 20, consecutive differing samples needed to accept a change (minimum 1).
- RESET_LEVEL, 1'b0, value loaded into synchronisers and stable outputs on reset.

Ports:
- clki  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  NUM_SW  asynchronous raw switch levels.
- sw_stable  output  NUM_SW  debounced switch levels.
- sw_rise  output  NUM_SW  one-cycle pulse when sw_stable goes 0->1.
- sw_fall  output  NUM_SW  one-cycle pulse when sw_stable goes 1->0.
- sample_tick  output  1  one-cycle sample strobe, exported for debug.

Behaviour:
- Interface: one clock, clki. Reset is synchronous and active-high, sampled on the rising edge of clki.
- Reset values: sync stages = RESET_LEVEL; sw_stable = {NUM_SW{RESET_LEVEL}}; sw_rise = 0; sw_fall = 0; sample_tick = 0; prescaler = 0; all confirm counters = 0; all channel FSMs = IDLE.
- Synchroniser: two flops per bit. sync_q is sw_raw delayed 2 cycles.
- Prescaler:
  - DIV = CLK_HZ/SAMPLE_HZ, computed at elaboration; DIV must be >= 2.
  - Counter runs 0..DIV-1 and wraps to 0.
  - sample_tick is registered and is 1 for exactly the cycle after the counter equals DIV-1.
  - First tick after reset release is at cycle DIV.
- Per-channel FSM, evaluated only on cycles where sample_tick = 1:
  - IDLE, sync_q == sw_stable: stay in IDLE, cnt = 0.
  - IDLE, sync_q != sw_stable: go to CONFIRM, cnt = 1.
    - If STABLE_SAMPLES == 1, accept immediately instead.
  - CONFIRM, sync_q == sw_stable (glitch): return to IDLE, cnt = 0. No output change.
  - CONFIRM, sync_q != sw_stable, cnt < STABLE_SAMPLES-1: cnt += 1.
  - CONFIRM, sync_q != sw_stable, cnt == STABLE_SAMPLES-1: accept. sw_stable <= sync_q; pulse sw_rise or sw_fall per direction; go to IDLE, cnt = 0.
- Counter width: $clog2(STABLE_SAMPLES+1). The counter never exceeds STABLE_SAMPLES-1.
- Pulses:
  - sw_rise and sw_fall are registered and high for exactly 1 clki cycle, in the same cycle sw_stable first shows the new value.
  - rise and fall for the same bit are never both high.
- Latency: a clean edge at sw_raw appears on sw_stable 2 cycles plus STABLE_SAMPLES ticks later, with up to 1 tick of phase jitter.
- Channels are independent. Simultaneous changes on several bits are accepted on the same tick if each meets the count.
- Reset mid-confirmation: the count is discarded, sw_stable returns to RESET_LEVEL, and no pulse is emitted in the reset cycle.
- Switch held at a level equal to RESET_LEVEL through reset: no pulse after release.

Decomposition:
- Shared package `switch_debouncer_pkg` holds:
  - channel index constants SW_MODE0 = 0, SW_MODE1 = 1, SW_PAUSE = 2;
  - state encoding DB_IDLE / DB_CONFIRM;
  - a function computing DIV and the counter width.
- One sub-module, `debounce_channel`: synchroniser, FSM, counter, edge pulses for one bit, driven by the shared sample_tick.
- The top generates NUM_SW instances plus a single prescaler.

Test Plan:
Sim parameters: CLK_HZ = 1000, SAMPLE_HZ = 100 (DIV = 10), STABLE_SAMPLES = 4, RESET_LEVEL = 0.
- Reset: hold reset 3 cycles with sw_raw = 3'b111, then release.
  - Required: all outputs 0 during reset; sample_tick first high at cycle 10 after release.
  - Required: sw_stable[2:0] = 3'b111 after the 4th tick; single sw_rise = 3'b111 pulse in that cycle.
- Clean edge: sw_raw[0] 0->1 held steady.
  - Required: sw_stable[0] = 1 after exactly 4 ticks; sw_rise[0] high 1 cycle; sw_fall[0] stays 0.
- Bounce: sw_raw[2] toggles 1,0,1 across 3 consecutive ticks, then holds 1.
  - Required: no change until 4 consecutive ticks at 1; exactly one sw_rise[2] pulse.
- Short glitch: sw_raw[1] high for 5 clki cycles between ticks.
  - Required: sw_stable[1] stays 0; no pulses.
- Simultaneous release: sw_raw 3'b111 -> 3'b000.
  - Required: sw_fall = 3'b111 in one cycle; sw_stable = 3'b000.
- Reset mid-confirm: assert reset after 2 of 4 confirming ticks.
  - Required: sw_stable = 0 and no pulse; the count restarts from 0 after release.
